float8_division: RTL and testbench

FLOAT8_DIVISION -- requirements
Module: float8_division

---
 rtl/float8_pkg.sv | 24 ++
 rtl/float8_mant_divider.sv | 73 +++++++
 rtl/float8_division.sv | 136 +++++++++++++
 tb/tb_float8_division.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/float8_pkg.sv
// Shared float8 format constants and FSM encoding.
// Used by the divider datapath and other float8 arithmetic blocks.
package float8_pkg;

    localparam int EXP_W    = 4;
    localparam int MANT_W   = 3;
    localparam int FP8_W    = 1 + EXP_W + MANT_W;
    localparam int SIGN_BIT = FP8_W - 1;
    localparam int BIAS     = 7;
    localparam int QUOT_W   = MANT_W + 2;
    localparam int EXP_MIN  = 1;
    localparam int EXP_MAX  = 15;

    localparam logic [FP8_W-2:0] MAX_MAG  = 7'h7F;
    localparam logic [FP8_W-2:0] ZERO_MAG = 7'h00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_NORMALIZE,
        S_DONE
    } state_e;

endpackage

// File: rtl/float8_mant_divider.sv
// Iterative restoring divider for hidden-bit mantissas.
// Loads on start, then produces one quotient bit per cycle, MSB first.
module float8_mant_divider
    import float8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MANT_W:0]   a_mant,
    input  logic [MANT_W:0]   b_mant,
    output logic [QUOT_W-1:0] quot,
    output logic              done
);

    logic [QUOT_W-1:0] rem_q, rem_d;
    logic [QUOT_W-1:0] rem_sub;
    logic [MANT_W:0]   div_q, div_d;
    logic [QUOT_W-1:0] q_q, q_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ge;

    // One restoring step per cycle while busy; done pulses after the last bit.
    always_comb begin
        rem_d   = rem_q;
        div_d   = div_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ge      = rem_q >= {1'b0, div_q};
        rem_sub = ge ? rem_q - {1'b0, div_q} : rem_q;
        if (start) begin
            rem_d  = {1'b0, a_mant};
            div_d  = b_mant;
            q_d    = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = rem_sub << 1;
            q_d   = {q_q[QUOT_W-2:0], ge};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(QUOT_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state registers, cleared by reset to abort any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            div_q  <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            div_q  <= div_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quot = q_q;
    assign done = done_q;

endmodule

// File: rtl/float8_division.sv
// Float8 divider with valid/ready handshakes and fixed latency.
// Zero operands and exponent range are resolved after the mantissa divide.
module float8_division
    import float8_pkg::*;
#(
    parameter int BIAS = float8_pkg::BIAS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP8_W-1:0] a,
    input  logic [FP8_W-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP8_W-1:0] result,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             underflow
);

    localparam logic signed [5:0] EXP_HI = 6'(EXP_MAX);
    localparam logic signed [5:0] EXP_LO = 6'(EXP_MIN);

    state_e            state_q, state_d;
    logic [FP8_W-1:0]  a_q, a_d;
    logic [FP8_W-1:0]  b_q, b_d;
    logic              sign_q, sign_d;
    logic [FP8_W-1:0]  result_q, result_d;
    logic              dbz_q, dbz_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              start;
    logic [QUOT_W-1:0] quot;
    logic              div_done;
    logic [EXP_W-1:0]  ea, eb;
    logic signed [5:0] exp_raw, exp_adj;
    logic [MANT_W-1:0] mant;

    float8_mant_divider u_div (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_mant ({1'b1, a[MANT_W-1:0]}),
        .b_mant ({1'b1, b[MANT_W-1:0]}),
        .quot   (quot),
        .done   (div_done)
    );

    // Sequencing plus exponent/normalize/special-case resolution.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        start    = 1'b0;
        ea       = a_q[FP8_W-2 -: EXP_W];
        eb       = b_q[FP8_W-2 -: EXP_W];
        exp_raw  = 6'({2'b00, ea}) - 6'({2'b00, eb}) + 6'(BIAS);
        exp_adj  = quot[QUOT_W-1] ? exp_raw : exp_raw - 6'sd1;
        mant     = quot[QUOT_W-1] ? quot[QUOT_W-2:1]
                                  : quot[MANT_W-1:0];
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sign_d  = a[SIGN_BIT] ^ b[SIGN_BIT];
                    start   = 1'b1;
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (div_done) state_d = S_NORMALIZE;
            end
            S_NORMALIZE: begin
                dbz_d = 1'b0;
                ovf_d = 1'b0;
                unf_d = 1'b0;
                if (eb == '0) begin
                    result_d = {sign_q, MAX_MAG};
                    dbz_d    = 1'b1;
                end else if (ea == '0) begin
                    result_d = {sign_q, ZERO_MAG};
                end else if (exp_adj > EXP_HI) begin
                    result_d = {sign_q, MAX_MAG};
                    ovf_d    = 1'b1;
                end else if (exp_adj < EXP_LO) begin
                    result_d = {sign_q, ZERO_MAG};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_adj[EXP_W-1:0], mant};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    // Control and result registers; reset aborts and clears outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE) && !rst;
    assign out_valid   = (state_q == S_DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_float8_division.sv
// Directed self-checking bench for float8_division.
// Each task drives one scenario and checks against hand-computed values.
module tb_float8_division;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       div_by_zero;
    logic       overflow;
    logic       underflow;

    int tests = 0;
    int fails = 0;

    float8_division #(.BIAS(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    // Accept one operation, wait for out_valid, check latency/result/flags,
    // and (when out_ready=1) the return to IDLE.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_,
                         input logic [7:0] er, input logic [2:0] ef,
                         input string nm);
        int lat;
        a = ta;
        b = tb_;
        in_valid = 1'b1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s in_ready_idle got %b exp 1", nm, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s in_ready_busy got %b exp 0", nm, in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tests++;
        if (lat != 7) begin
            fails++;
            $display("FAIL %s latency got %0d exp 7", nm, lat);
        end
        tests++;
        if (result !== er) begin
            fails++;
            $display("FAIL %s result got %h exp %h", nm, result, er);
        end
        tests++;
        if ({div_by_zero, overflow, underflow} !== ef) begin
            fails++;
            $display("FAIL %s flags got %b exp %b", nm,
                     {div_by_zero, overflow, underflow}, ef);
        end
        if (out_ready) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL %s to_idle got ov=%b ir=%b exp ov=0 ir=1",
                         nm, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        a = 8'h00;
        b = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || result !== 8'h00 || in_ready !== 1'b0 ||
            {div_by_zero, overflow, underflow} !== 3'b000) begin
            fails++;
            $display("FAIL reset_state got ov=%b r=%h ir=%b f=%b exp 0 00 0 000",
                     out_valid, result, in_ready,
                     {div_by_zero, overflow, underflow});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_normal();
        do_op(8'h44, 8'h3C, 8'h40, 3'b000, "3.0/1.5");
        do_op(8'h38, 8'h3C, 8'h32, 3'b000, "1.0/1.5");
        do_op(8'hC0, 8'h38, 8'hC0, 3'b000, "-2.0/1.0");
    endtask

    task automatic test_specials();
        do_op(8'h38, 8'h00, 8'h7F, 3'b100, "div_zero");
        do_op(8'h00, 8'hB8, 8'h80, 3'b000, "zero_num");
        do_op(8'h78, 8'h08, 8'h7F, 3'b010, "overflow");
        do_op(8'h08, 8'h78, 8'h00, 3'b001, "underflow");
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        do_op(8'h38, 8'h3C, 8'h32, 3'b000, "stall_op");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 8'h44;
            b = 8'h3C;
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || result !== 8'h32 || in_ready !== 1'b0 ||
                {div_by_zero, overflow, underflow} !== 3'b000) begin
                fails++;
                $display("FAIL stall_hold got ov=%b r=%h ir=%b exp 1 32 0",
                         out_valid, result, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release got ov=%b ir=%b exp 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_midreset();
        a = 8'h38;
        b = 8'h3C;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || result !== 8'h00 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL midreset got ov=%b r=%h ir=%b exp 0 00 0",
                     out_valid, result, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_release got ir=%b ov=%b exp 1 0",
                     in_ready, out_valid);
        end
        do_op(8'h44, 8'h3C, 8'h40, 3'b000, "after_reset");
    endtask

    task automatic test_back_to_back();
        do_op(8'h44, 8'h38, 8'h44, 3'b000, "b2b_first");
        do_op(8'hB8, 8'h3C, 8'hB2, 3'b000, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_normal();
        test_specials();
        test_stall();
        do_op(8'h44, 8'h3C, 8'h40, 3'b000, "post_stall");
        test_midreset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
